address_generator: RTL and testbench

- Address generator stage feeding the neuron control unit and ALU.
- Walks the input-vector memory and the weight memory for a fully-connected layer: N_INPUTS addresses per neuron, N_NEURONS neurons.
- Driven by the control unit's AG_rst / AG_read strobes.
- Emits address pairs plus a delayed data-valid/last qualifier aligned to memory read latency, so the ALU knows when operands arrive and when a neuron's dot product ends.

---
 rtl/address_generator_if.sv | 29 ++
 rtl/address_generator.sv | 157 +++++++++++++++
 tb/tb_address_generator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/address_generator_if.sv
// Handshake and address bus between the neuron control unit / ALU side
// (master) and the address generator (slave).
interface address_generator_if #(
    parameter int ADDR_W = 8
);
    logic              AG_rst;
    logic              AG_read;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] w_addr;
    logic              addr_valid;
    logic              last_input;
    logic              last_neuron;
    logic [ADDR_W-1:0] neuron_idx;
    logic              data_valid;
    logic              data_last;
    logic              done;

    modport master (
        output AG_rst, AG_read,
        input  x_addr, w_addr, addr_valid, last_input, last_neuron,
               neuron_idx, data_valid, data_last, done
    );

    modport slave (
        input  AG_rst, AG_read,
        output x_addr, w_addr, addr_valid, last_input, last_neuron,
               neuron_idx, data_valid, data_last, done
    );
endinterface

// File: rtl/address_generator.sv
// Address generator for a fully-connected layer: walks the input vector
// (N_INPUTS per neuron) and the neuron-major weight block, one address pair
// per AG_read, and delays the valid/last qualifiers by the memory latency.
module address_generator #(
    parameter int ADDR_W    = 8,
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 4,
    parameter int X_BASE    = 0,
    parameter int W_BASE    = 0,
    parameter int MEM_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    address_generator_if.slave  bus
);

    localparam int I_W = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1;
    localparam int N_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    localparam logic [I_W-1:0]    I_LAST = I_W'(N_INPUTS - 1);
    localparam logic [N_W-1:0]    N_LAST = N_W'(N_NEURONS - 1);
    localparam logic [ADDR_W-1:0] X_B    = ADDR_W'(X_BASE);
    localparam logic [ADDR_W-1:0] W_B    = ADDR_W'(W_BASE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [I_W-1:0]    i_q, i_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0] wp_q, wp_d;

    logic              issue;
    logic              final_issue;
    logic              i_last;
    logic              n_last;

    logic [ADDR_W-1:0] x_addr_q, w_addr_q, neuron_idx_q;
    logic              addr_valid_q, last_input_q, last_neuron_q, done_q;

    // {valid, last} shift register matching the memory read latency
    logic [1:0]        dly_q [MEM_LAT];

    assign i_last = (i_q == I_LAST);
    assign n_last = (n_q == N_LAST);

    // State register and walk counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            n_q     <= '0;
            wp_q    <= W_B;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            n_q     <= n_d;
            wp_q    <= wp_d;
        end
    end

    // Next-state, counter advance and issue decision
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        n_d         = n_q;
        wp_d        = wp_q;
        issue       = 1'b0;
        final_issue = 1'b0;

        if (bus.AG_rst) begin
            state_d = S_IDLE;
            i_d     = '0;
            n_d     = '0;
            wp_d    = W_B;
        end else begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (bus.AG_read) begin
                        issue = 1'b1;
                        // The final issue freezes the counters so a later
                        // restart only happens through AG_rst/reset.
                        if (i_last && n_last) begin
                            final_issue = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_RUN;
                            wp_d    = wp_q + ADDR_W'(1);
                            if (i_last) begin
                                i_d = '0;
                                n_d = n_q + N_W'(1);
                            end else begin
                                i_d = i_q + I_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered address pair, qualifiers and sticky done flag
    always_ff @(posedge clk) begin
        if (!reset || bus.AG_rst) begin
            x_addr_q      <= X_B;
            w_addr_q      <= W_B;
            neuron_idx_q  <= '0;
            addr_valid_q  <= 1'b0;
            last_input_q  <= 1'b0;
            last_neuron_q <= 1'b0;
            done_q        <= 1'b0;
        end else if (issue) begin
            x_addr_q      <= X_B + ADDR_W'(i_q);
            w_addr_q      <= wp_q;
            neuron_idx_q  <= ADDR_W'(n_q);
            addr_valid_q  <= 1'b1;
            last_input_q  <= i_last;
            last_neuron_q <= n_last;
            if (final_issue) begin
                done_q <= 1'b1;
            end
        end else begin
            addr_valid_q  <= 1'b0;
            last_input_q  <= 1'b0;
            last_neuron_q <= 1'b0;
        end
    end

    // Memory-latency delay line for data_valid/data_last
    always_ff @(posedge clk) begin
        if (!reset || bus.AG_rst) begin
            for (int unsigned k = 0; k < MEM_LAT; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            dly_q[0] <= {addr_valid_q, last_input_q};
            for (int unsigned k = 1; k < MEM_LAT; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
        end
    end

    assign bus.x_addr      = x_addr_q;
    assign bus.w_addr      = w_addr_q;
    assign bus.neuron_idx  = neuron_idx_q;
    assign bus.addr_valid  = addr_valid_q;
    assign bus.last_input  = last_input_q;
    assign bus.last_neuron = last_neuron_q;
    assign bus.done        = done_q;
    assign bus.data_valid  = dly_q[MEM_LAT-1][1];
    assign bus.data_last   = dly_q[MEM_LAT-1][0];

endmodule

// File: tb/tb_address_generator.sv
// Bench for address_generator: two instances (default configuration and a
// wrapping 2x2 / latency-3 configuration) share one stimulus stream and are
// compared every cycle against an issue-count reference model.
module tb_address_generator;

    logic clk = 1'b0;
    logic rst_n;
    logic ag_rst;
    logic ag_read;

    always #5 clk = ~clk;

    address_generator_if #(.ADDR_W(8)) if0 ();
    address_generator_if #(.ADDR_W(8)) if1 ();

    assign if0.AG_rst  = ag_rst;
    assign if0.AG_read = ag_read;
    assign if1.AG_rst  = ag_rst;
    assign if1.AG_read = ag_read;

    address_generator #(
        .ADDR_W(8), .N_INPUTS(4), .N_NEURONS(4),
        .X_BASE(0), .W_BASE(0), .MEM_LAT(1)
    ) dut0 (
        .clk(clk), .reset(rst_n), .bus(if0.slave)
    );

    address_generator #(
        .ADDR_W(8), .N_INPUTS(2), .N_NEURONS(2),
        .X_BASE('h40), .W_BASE('hFE), .MEM_LAT(3)
    ) dut1 (
        .clk(clk), .reset(rst_n), .bus(if1.slave)
    );

    // Reference configuration per instance
    int NI  [2] = '{4, 2};
    int NN  [2] = '{4, 2};
    int XB  [2] = '{'h00, 'h40};
    int WB  [2] = '{'h00, 'hFE};
    int LAT [2] = '{1, 3};

    // Reference model state: k = number of pairs issued since last clear
    int         k_m    [2];
    logic       v_m    [2];
    logic       li_m   [2];
    logic       ln_m   [2];
    logic       done_m [2];
    logic [7:0] x_m    [2];
    logic [7:0] w_m    [2];
    logic [7:0] n_m    [2];
    logic       vlog   [2][4096];
    logic       llog   [2][4096];
    int         cyc      = 0;
    int         last_clr = 0;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input int c);
        if (!rst_n || ag_rst) begin
            k_m[c]    = 0;
            v_m[c]    = 1'b0;
            li_m[c]   = 1'b0;
            ln_m[c]   = 1'b0;
            done_m[c] = 1'b0;
            x_m[c]    = 8'(XB[c]);
            w_m[c]    = 8'(WB[c]);
            n_m[c]    = 8'd0;
        end else if (ag_read && !done_m[c]) begin
            x_m[c]  = 8'(XB[c] + k_m[c] % NI[c]);
            w_m[c]  = 8'(WB[c] + k_m[c]);
            n_m[c]  = 8'(k_m[c] / NI[c]);
            v_m[c]  = 1'b1;
            li_m[c] = (k_m[c] % NI[c]) == NI[c] - 1;
            ln_m[c] = (k_m[c] / NI[c]) == NN[c] - 1;
            k_m[c]++;
            if (k_m[c] == NI[c] * NN[c]) done_m[c] = 1'b1;
        end else begin
            v_m[c]  = 1'b0;
            li_m[c] = 1'b0;
            ln_m[c] = 1'b0;
        end
        vlog[c][cyc % 4096] = v_m[c];
        llog[c][cyc % 4096] = li_m[c];
    endtask

    task automatic compare(input int c);
        logic [7:0] x, w, n;
        logic       v, li, ln, dv, dl, dn;
        logic       edv, edl;
        string      p;
        if (c == 0) begin
            x = if0.x_addr; w = if0.w_addr; n = if0.neuron_idx;
            v = if0.addr_valid; li = if0.last_input; ln = if0.last_neuron;
            dv = if0.data_valid; dl = if0.data_last; dn = if0.done;
        end else begin
            x = if1.x_addr; w = if1.w_addr; n = if1.neuron_idx;
            v = if1.addr_valid; li = if1.last_input; ln = if1.last_neuron;
            dv = if1.data_valid; dl = if1.data_last; dn = if1.done;
        end
        // A clear wipes everything in flight; older history is not visible
        if (cyc - LAT[c] >= last_clr) begin
            edv = vlog[c][(cyc - LAT[c]) % 4096];
            edl = llog[c][(cyc - LAT[c]) % 4096];
        end else begin
            edv = 1'b0;
            edl = 1'b0;
        end
        p = (c == 0) ? "d0" : "d1";
        check_val({p, ".x_addr"},      32'(x),  32'(x_m[c]));
        check_val({p, ".w_addr"},      32'(w),  32'(w_m[c]));
        check_val({p, ".neuron_idx"},  32'(n),  32'(n_m[c]));
        check_val({p, ".addr_valid"},  32'(v),  32'(v_m[c]));
        check_val({p, ".last_input"},  32'(li), 32'(li_m[c]));
        check_val({p, ".last_neuron"}, 32'(ln), 32'(ln_m[c]));
        check_val({p, ".data_valid"},  32'(dv), 32'(edv));
        check_val({p, ".data_last"},   32'(dl), 32'(edl));
        check_val({p, ".done"},        32'(dn), 32'(done_m[c]));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n || ag_rst) last_clr = cyc;
        model_edge(0);
        model_edge(1);
        #1;
        compare(0);
        compare(1);
    endtask

    initial begin
        rst_n   = 1'b0;
        ag_rst  = 1'b0;
        ag_read = 1'b0;

        // Reset for two cycles
        tick();
        tick();
        rst_n = 1'b1;

        // Contiguous walk of the whole layer, then 5 reads ignored in DONE
        ag_read = 1'b1;
        repeat (21) tick();

        // Forget and restart
        ag_read = 1'b0;
        ag_rst  = 1'b1;
        tick();
        ag_rst  = 1'b0;

        // Gapped reads 1,0,1,0,...
        for (int j = 0; j < 34; j++) begin
            ag_read = (j % 2 == 0);
            tick();
        end

        // AG_rst after six issues, with AG_read still high
        ag_read = 1'b0;
        ag_rst  = 1'b1;
        tick();
        ag_rst  = 1'b0;
        ag_read = 1'b1;
        repeat (6) tick();
        ag_rst = 1'b1;
        tick();
        ag_rst = 1'b0;
        repeat (3) tick();

        // Reset mid-walk while AG_read is high
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Randomized control traffic
        for (int j = 0; j < 600; j++) begin
            rst_n   = ($urandom_range(0, 59) != 0);
            ag_rst  = ($urandom_range(0, 29) == 0);
            ag_read = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
